// File: rtl/scaler_chain_param.sv
`default_nettype none
// ============================================================================
// Module   : scaler_chain_param
// Desc     : Synchronous binary scaler chain driven by FS01_, with per-stage
//            phase pulses, freeze, coherent two-channel readout, stall alarm.
// Revision : 1.0 - initial release
// ============================================================================
module scaler_chain_param #(
    parameter int NUM_STAGES   = 33,
    parameter int CHAN_WIDTH   = 14,
    parameter int CHAN_A_LSB   = 0,
    parameter int CHAN_B_LSB   = 14,
    parameter int STALL_CYCLES = 1024
) (
    input  logic                  SIM_CLK,
    input  logic                  SIM_RST,
    input  logic                  FS01_,
    input  logic                  FREEZE,
    input  logic                  RCHAT_,
    input  logic                  RCHBT_,
    output logic [NUM_STAGES-2:0] FS,
    output logic [NUM_STAGES-2:0] FA,
    output logic [NUM_STAGES-2:0] FB,
    output logic [CHAN_WIDTH-1:0] CHAN_DATA,
    output logic                  CHAN_VALID,
    output logic                  CHAN_SEL,
    output logic                  STALL
);

    localparam int c_W     = NUM_STAGES - 1;
    localparam int c_CNT_W = $clog2(STALL_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_STALL_MAX = c_CNT_W'(STALL_CYCLES);

    if (NUM_STAGES < 3 || NUM_STAGES > 33 || CHAN_WIDTH > c_W ||
        CHAN_A_LSB + CHAN_WIDTH > c_W || CHAN_B_LSB + CHAN_WIDTH > c_W ||
        STALL_CYCLES < 2) begin : g_param_check
        $error("scaler_chain_param: illegal parameter combination");
    end

    logic                  r_fs01_d;
    logic                  r_rcha_d;
    logic                  r_rchb_d;
    logic [c_W-1:0]        r_fs;
    logic [c_W-1:0]        r_fa;
    logic [c_W-1:0]        r_fb;
    logic [CHAN_WIDTH-1:0] r_shadow_b;
    logic                  r_shadow_valid;
    logic                  r_pend_b;
    logic [CHAN_WIDTH-1:0] r_chan_data;
    logic                  r_chan_valid;
    logic                  r_chan_sel;
    logic [c_CNT_W-1:0]    r_stall_cnt;

    logic                  w_adv;
    logic                  w_trans;
    logic                  w_rcha_edge;
    logic                  w_rchb_edge;
    logic                  w_service_b;
    logic [c_W-1:0]        w_fs_inc;

    // FS01_ rising is the falling edge of the active-high stage-1 signal
    assign w_adv       = ~r_fs01_d & FS01_;
    assign w_trans     = r_fs01_d ^ FS01_;
    assign w_rcha_edge = r_rcha_d & ~RCHAT_;
    assign w_rchb_edge = r_rchb_d & ~RCHBT_;
    assign w_service_b = w_rchb_edge | r_pend_b;
    assign w_fs_inc    = r_fs + c_W'(1);

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            r_fs01_d <= 1'b1;
            r_rcha_d <= 1'b1;
            r_rchb_d <= 1'b1;
            r_fs     <= '0;
            r_fa     <= '0;
            r_fb     <= '0;
        end else begin
            r_fs01_d <= FS01_;
            r_rcha_d <= RCHAT_;
            r_rchb_d <= RCHBT_;
            if (w_adv && !FREEZE) begin
                r_fs <= w_fs_inc;
                r_fa <= r_fs & ~w_fs_inc;
                r_fb <= ~r_fs & w_fs_inc;
            end else begin
                r_fa <= '0;
                r_fb <= '0;
            end
        end
    end

    // A read wins a tie; B then follows from the snapshot A just took.
    // Only the B window of the snapshot is ever read back, so only it is held.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            r_shadow_b     <= '0;
            r_shadow_valid <= 1'b0;
            r_pend_b       <= 1'b0;
            r_chan_data    <= '0;
            r_chan_valid   <= 1'b0;
            r_chan_sel     <= 1'b0;
        end else begin
            r_chan_valid <= 1'b0;
            if (w_rcha_edge) begin
                r_chan_data    <= r_fs[CHAN_A_LSB +: CHAN_WIDTH];
                r_chan_sel     <= 1'b0;
                r_chan_valid   <= 1'b1;
                r_shadow_b     <= r_fs[CHAN_B_LSB +: CHAN_WIDTH];
                r_shadow_valid <= 1'b1;
                if (w_rchb_edge) begin
                    r_pend_b <= 1'b1;
                end
            end else if (w_service_b) begin
                r_chan_data    <= r_shadow_valid ? r_shadow_b
                                                 : r_fs[CHAN_B_LSB +: CHAN_WIDTH];
                r_chan_sel     <= 1'b1;
                r_chan_valid   <= 1'b1;
                r_shadow_valid <= 1'b0;
                r_pend_b       <= 1'b0;
            end
        end
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            r_stall_cnt <= '0;
        end else if (w_trans) begin
            r_stall_cnt <= '0;
        end else if (r_stall_cnt != c_STALL_MAX) begin
            r_stall_cnt <= r_stall_cnt + c_CNT_W'(1);
        end
    end

    assign FS         = r_fs;
    assign FA         = r_fa;
    assign FB         = r_fb;
    assign CHAN_DATA  = r_chan_data;
    assign CHAN_VALID = r_chan_valid;
    assign CHAN_SEL   = r_chan_sel;
    assign STALL      = (r_stall_cnt == c_STALL_MAX);

endmodule
`default_nettype wire

// File: tb/tb_scaler_chain_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_scaler_chain_param
// Desc     : Self-checking bench for scaler_chain_param (W=32 and W=4 copies).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_scaler_chain_param;

    localparam int W     = 32;
    localparam int CW    = 14;
    localparam int A_LSB = 0;
    localparam int B_LSB = 14;

    typedef struct packed {
        logic          sel;
        logic [CW-1:0] data;
        logic [1:0]    sdata;
    } rd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, fs01_n, freeze, rcha_n, rchb_n;
    logic [W-1:0]  fs, fa, fb;
    logic [CW-1:0] chan_data;
    logic          chan_valid, chan_sel, stall;
    logic [3:0]    s_fs, s_fa, s_fb;
    logic [1:0]    s_data;
    logic          s_valid, s_sel, s_stall;

    scaler_chain_param #(
        .NUM_STAGES(33), .CHAN_WIDTH(CW), .CHAN_A_LSB(A_LSB),
        .CHAN_B_LSB(B_LSB), .STALL_CYCLES(8)
    ) dut (
        .SIM_CLK(clk), .SIM_RST(rst), .FS01_(fs01_n), .FREEZE(freeze),
        .RCHAT_(rcha_n), .RCHBT_(rchb_n), .FS(fs), .FA(fa), .FB(fb),
        .CHAN_DATA(chan_data), .CHAN_VALID(chan_valid), .CHAN_SEL(chan_sel),
        .STALL(stall)
    );

    scaler_chain_param #(
        .NUM_STAGES(5), .CHAN_WIDTH(2), .CHAN_A_LSB(0),
        .CHAN_B_LSB(2), .STALL_CYCLES(8)
    ) dut_small (
        .SIM_CLK(clk), .SIM_RST(rst), .FS01_(fs01_n), .FREEZE(freeze),
        .RCHAT_(rcha_n), .RCHBT_(rchb_n), .FS(s_fs), .FA(s_fa), .FB(s_fb),
        .CHAN_DATA(s_data), .CHAN_VALID(s_valid), .CHAN_SEL(s_sel),
        .STALL(s_stall)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] cnt      = '0;
    logic [63:0] sh       = '0;
    bit          sh_v     = 1'b0;
    rd_t         sb_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        fs01_n = 1'b1;
        rcha_n = 1'b1;
        rchb_n = 1'b1;
        freeze = 1'b0;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
        cnt    = '0;
        sh_v   = 1'b0;
    endtask

    // One FS01_ period of 4 clocks; checks the counter and the phase pulses.
    task automatic adv_event(output logic [W-1:0] fa_seen, output logic [W-1:0] fb_seen,
                             output logic [3:0] sfa_seen);
        logic [W-1:0] o, n;
        logic         adv_on;
        o      = cnt[W-1:0];
        n      = o + 1;
        adv_on = !freeze;
        fs01_n = 1'b0;
        tick();
        tick();
        fs01_n = 1'b1;
        tick();
        if (adv_on) cnt = cnt + 1;
        fa_seen  = fa;
        fb_seen  = fb;
        sfa_seen = s_fa;
        check_eq("fs", fs, cnt[W-1:0]);
        check_eq("s_fs", s_fs, cnt[3:0]);
        check_eq("fa", fa, adv_on ? (o & ~n) : '0);
        check_eq("fb", fb, adv_on ? (~o & n) : '0);
        check_eq("s_fa", s_fa, adv_on ? (o[3:0] & ~n[3:0]) : 4'h0);
        check_eq("s_fb", s_fb, adv_on ? (~o[3:0] & n[3:0]) : 4'h0);
        tick();
        check_eq("fa_idle", fa, 0);
        check_eq("fb_idle", fb, 0);
    endtask

    task automatic fast_adv(input int n);
        for (int i = 0; i < n; i++) begin
            fs01_n = 1'b0;
            tick();
            fs01_n = 1'b1;
            tick();
            cnt = cnt + 1;
        end
    endtask

    task automatic do_read(input bit a, input bit b);
        rd_t e;
        if (a) begin
            e.sel   = 1'b0;
            e.data  = cnt[A_LSB +: CW];
            e.sdata = cnt[1:0];
            sb_q.push_back(e);
            sh   = cnt;
            sh_v = 1'b1;
        end
        if (b) begin
            e.sel   = 1'b1;
            e.data  = sh_v ? sh[B_LSB +: CW] : cnt[B_LSB +: CW];
            e.sdata = sh_v ? sh[3:2] : cnt[3:2];
            sb_q.push_back(e);
            sh_v = 1'b0;
        end
        if (a) rcha_n = 1'b0;
        if (b) rchb_n = 1'b0;
        tick();
        rcha_n = 1'b1;
        rchb_n = 1'b1;
        tick();
        tick();
    endtask

    // Read-response monitor: every CHAN_VALID must match the oldest expectation
    always @(negedge clk) begin
        rd_t e;
        if (chan_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("chan_spurious", chan_valid, 0);
            end else begin
                e = sb_q.pop_front();
                check_eq("chan_sel", chan_sel, e.sel);
                check_eq("chan_data", chan_data, e.data);
                check_eq("s_chan_valid", s_valid, 1);
                check_eq("s_chan_sel", s_sel, e.sel);
                check_eq("s_chan_data", s_data, e.sdata);
            end
        end
    end

    initial begin
        #10ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] fa_s, fb_s;
        logic [3:0]   sfa_s;

        do_reset();
        rst = 1'b1;
        tick();
        check_eq("rst_fs", fs, 0);
        check_eq("rst_fa", fa, 0);
        check_eq("rst_fb", fb, 0);
        check_eq("rst_chan_data", chan_data, 0);
        check_eq("rst_chan_valid", chan_valid, 0);
        check_eq("rst_chan_sel", chan_sel, 0);
        check_eq("rst_stall", stall, 0);
        rst = 1'b0;

        // 16 events: W=32 reaches 16, W=4 wraps from all ones to zero
        for (int i = 1; i <= 16; i++) begin
            adv_event(fa_s, fb_s, sfa_s);
            check_eq("fb0_odd", fb_s[0], (i % 2) == 1);
            check_eq("fa3_ev16", fa_s[3], i == 16);
            if (i == 15) check_eq("s_fs_allones", s_fs, 4'hF);
            if (i == 16) check_eq("s_wrap_fa", sfa_s, 4'hF);
        end
        check_eq("fs_16", fs, 16);
        check_eq("s_fs_wrap", s_fs, 0);
        check_eq("s_fb_after_wrap", s_fb, 0);
        check_eq("stall_while_toggling", stall, 0);

        // Freeze drops events without catch-up
        do_reset();
        for (int i = 0; i < 7; i++) adv_event(fa_s, fb_s, sfa_s);
        check_eq("fs_7", fs, 7);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) adv_event(fa_s, fb_s, sfa_s);
        check_eq("fs_frozen", fs, 7);
        freeze = 1'b0;
        adv_event(fa_s, fb_s, sfa_s);
        check_eq("fs_8", fs, 8);

        // Coherent A-then-B across a carry into the B window
        do_reset();
        fast_adv(16381);
        check_eq("fs_preset", fs, 16381);
        do_read(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) adv_event(fa_s, fb_s, sfa_s);
        check_eq("fs_after5", fs, 16386);
        do_read(1'b0, 1'b1);
        do_read(1'b0, 1'b1);

        // Simultaneous A and B: two back-to-back responses from one snapshot
        do_read(1'b1, 1'b1);

        // Reset between the A and B responses discards the pending B
        sb_q.push_back('{sel: 1'b0, data: cnt[A_LSB +: CW], sdata: cnt[1:0]});
        rcha_n = 1'b0;
        rchb_n = 1'b0;
        tick();
        rst    = 1'b1;
        rcha_n = 1'b1;
        rchb_n = 1'b1;
        tick();
        check_eq("gap_rst_fs", fs, 0);
        check_eq("gap_rst_chan_valid", chan_valid, 0);
        check_eq("gap_rst_chan_data", chan_data, 0);
        check_eq("gap_rst_chan_sel", chan_sel, 0);
        rst  = 1'b0;
        cnt  = '0;
        sh_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("no_pending_b", chan_valid, 0);
        end

        // Stall alarm at 8 idle cycles, clears on the next transition
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_eq("stall_hold", stall, i >= 8);
            check_eq("s_stall_hold", s_stall, i >= 8);
        end
        fs01_n = 1'b0;
        tick();
        check_eq("stall_clear", stall, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_eq("stall_restart", stall, i == 8);
        end
        fs01_n = 1'b1;
        tick();

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) tick();
        check_eq("sb_drain", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scaler_chain_param.md
Name: scaler_chain_param

Overview:
- Parametrised, synchronous successor to the hand-wired A1 NOR-gate scaler stages.
- Divides the stage-1 square wave FS01_ through a configurable number of binary stages. Each stage provides a level output and two single-cycle phase pulses per stage.
- Adds features the fixed four-stage version lacks: freeze, a coherent two-channel parallel readout (RCHAT_/RCHBT_), and an oscillator-stall alarm.
- Sits between the timing generator and the channel/alarm logic.

Parameters:
- NUM_STAGES, 33: highest stage number. Stages 2..NUM_STAGES are implemented, giving W = NUM_STAGES-1 bits. Legal range 3..33.
- CHAN_WIDTH, 14: width of the parallel read bus. Requires CHAN_WIDTH <= W.
- CHAN_A_LSB, 0: bit index into the stage vector (bit 0 = stage 2) of the channel A LSB. Requires CHAN_A_LSB+CHAN_WIDTH <= W.
- CHAN_B_LSB, 14: bit index of the channel B LSB, with the same constraint.
- STALL_CYCLES, 1024: SIM_CLK cycles without an FS01_ transition before STALL asserts. Must be >= 2.

Ports:
- SIM_CLK  in  1  system clock; all state updates on the rising edge.
- SIM_RST  in  1  synchronous reset, active-high.
- FS01_  in  1  stage-1 level, active-low; already synchronous to SIM_CLK.
- FREEZE  in  1  when high, stage advance is inhibited.
- RCHAT_  in  1  channel A read request, active-low; the falling edge is the event.
- RCHBT_  in  1  channel B read request, active-low; the falling edge is the event.
- FS  out  W  stage levels; bit k = stage k+2.
- FA  out  W  bit k pulses for one cycle when stage k+2 goes 1->0 (carry out).
- FB  out  W  bit k pulses for one cycle when stage k+2 goes 0->1.
- CHAN_DATA  out  CHAN_WIDTH  read result; holds its value until the next read.
- CHAN_VALID  out  1  one-cycle strobe marking new CHAN_DATA.
- CHAN_SEL  out  1  source of the current CHAN_DATA: 0 = A, 1 = B.
- STALL  out  1  oscillator-stall alarm, level output.

Behaviour:
- Reset (SIM_RST=1 at a clock edge):
  - FS, FA, FB, CHAN_DATA, CHAN_SEL, CHAN_VALID, STALL all 0.
  - Stall counter 0, shadow-valid flag 0, pending-B flag 0.
  - Input history registers for FS01_, RCHAT_ and RCHBT_ all set to 1, so no spurious edge is detected on the first cycle.
  - Reset overrides every other input. A pending B read is discarded.
- Advance event ADV: FS01_ history = 0 and current FS01_ = 1 (the FS01 falling edge). The history register updates every cycle, including while FREEZE is high.
- Counting:
  - ADV & !FREEZE at an edge: FS <= FS+1 (mod 2^W). Result is visible one cycle after FS01_ changes.
  - Concurrently, FA/FB are registered from the toggling bits: FA = old & ~new, FB = ~old & new, masked to the bits that toggled.
  - All other cycles FA = FB = 0. FA and FB are never high for the same bit in the same cycle.
- Wrap-around: FS all ones + ADV gives FS = 0. Every FA bit pulses in that cycle; FB stays 0.
- FREEZE:
  - An ADV during FREEZE is lost; there is no catch-up after release.
  - FA/FB stay 0 while frozen.
  - Reads still operate.
- Channel A read (RCHAT_ falling edge detected):
  - Next cycle: CHAN_DATA = FS[CHAN_A_LSB +: CHAN_WIDTH], CHAN_SEL = 0, CHAN_VALID = 1.
  - The full FS vector is copied into a shadow register and shadow-valid is set.
  - The captured value is FS as it stands before any same-cycle increment.
- Channel B read:
  - If shadow-valid = 1: data comes from the shadow, then shadow-valid is cleared. This makes an A-then-B pair coherent.
  - If shadow-valid = 0: data comes from live FS.
  - Either way CHAN_SEL = 1 and CHAN_VALID = 1 one cycle after the edge.
- Simultaneous A and B edges:
  - A is serviced first. B is latched in pending-B and serviced the following cycle from the new shadow, giving two consecutive CHAN_VALID pulses.
  - A further B edge while B is pending is merged (one response).
- Stall detection:
  - Counter increments each cycle with no FS01_ transition (either direction) and saturates at STALL_CYCLES.
  - Counter resets to 0 on any FS01_ transition.
  - STALL = (counter == STALL_CYCLES), so STALL clears the cycle after a transition.
  - FREEZE does not affect stall detection.

Test Plan:
1. Reset, then toggle FS01_ with period 4 SIM_CLK for 16 ADV events, W=32 -> FS = 16. FB[0] pulses on events 1,3,5,..., and FA[3] pulses once, at event 16.
2. Preset FS to all ones via 2^W-1 events (use NUM_STAGES=5, W=4, 15 events), then one more ADV -> FS = 0 and FA = 4'b1111 for exactly one cycle, FB = 0.
3. FREEZE=1 across 3 ADV events starting at FS = 7, then release and apply 1 ADV -> FS = 8; FA/FB remain 0 during the freeze.
4. FS = 0x0003_C000. RCHAT_ falls, then 5 ADV events, then RCHBT_ falls -> A returns 0x0000 (bits 13:0), B returns 0x000F (bits 27:14 from the shadow). A second B read returns live bits 27:14.
5. RCHAT_ and RCHBT_ fall in the same cycle -> CHAN_VALID high two consecutive cycles with CHAN_SEL = 0 then 1, both from the same snapshot. Assert SIM_RST in the gap -> second pulse absent and all outputs 0.
6. STALL_CYCLES=8, hold FS01_ constant -> STALL = 1 on cycle 8. Toggle FS01_ -> STALL = 0 the next cycle and the counter restarts.
